// File: rtl/exu_muldiv_iter_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit: funct3 codes,
// FSM states and zero constants.
package exu_muldiv_iter_pkg;

  localparam logic [2:0] INST_MUL    = 3'd0;
  localparam logic [2:0] INST_MULH   = 3'd1;
  localparam logic [2:0] INST_MULHSU = 3'd2;
  localparam logic [2:0] INST_MULHU  = 3'd3;
  localparam logic [2:0] INST_DIV    = 3'd4;
  localparam logic [2:0] INST_DIVU   = 3'd5;
  localparam logic [2:0] INST_REM    = 3'd6;
  localparam logic [2:0] INST_REMU   = 3'd7;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic [4:0]  ZeroReg  = 5'd0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  // funct3[2] separates the divide family from the multiply family.
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/exu_muldiv_iter_if.sv
// Request/stall/writeback bundle between execute control and the muldiv unit;
// master is the pipeline side, slave is the unit.
interface exu_muldiv_iter_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            rd_we_i;
  logic [4:0]      rd_waddr_i;
  logic            kill_i;
  logic            busy_o;
  logic            req_muldiv_o;
  logic            muldiv_reg_we_o;
  logic [4:0]      muldiv_reg_waddr_o;
  logic [XLEN-1:0] muldiv_reg_wdata_o;

  modport master (
    output req_i, op_i, rs1_i, rs2_i, rd_we_i, rd_waddr_i, kill_i,
    input  busy_o, req_muldiv_o, muldiv_reg_we_o, muldiv_reg_waddr_o, muldiv_reg_wdata_o
  );

  modport slave (
    input  req_i, op_i, rs1_i, rs2_i, rd_we_i, rd_waddr_i, kill_i,
    output busy_o, req_muldiv_o, muldiv_reg_we_o, muldiv_reg_waddr_o, muldiv_reg_wdata_o
  );
endinterface

// File: rtl/exu_muldiv_iter.sv
// Iterative RV32M multiply/divide: one bit per cycle over 32 cycles, result
// presented as a one-cycle register write to the commit mux.
module exu_muldiv_iter
  import exu_muldiv_iter_pkg::*;
#(
  parameter int unsigned XLEN  = 32,  // only 32 is supported
  parameter int unsigned CNT_W = 6
) (
  input logic              clk,
  input logic              rst,
  exu_muldiv_iter_if.slave bus
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                rd_we_q, rd_we_d;
  logic [4:0]          waddr_q, waddr_d;
  logic                neg_q, neg_d;
  logic [2*XLEN-1:0]   a_q, a_d;     // shifted multiplicand
  logic [XLEN-1:0]     b_q, b_d;     // multiplier (shifted right) or divisor
  logic [2*XLEN-1:0]   acc_q, acc_d; // product, or {remainder, quotient/dividend}
  logic [XLEN-1:0]     res_q, res_d;

  logic              accept;
  logic              rs1_neg, rs2_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;
  logic              neg_acc;
  logic [XLEN:0]     div_tmp, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] acc_step, prod_fix;
  logic [XLEN-1:0]   div_sel;

  assign accept = (state_q == StIdle) & bus.req_i & ~bus.kill_i;

  // Operand signs: MULHSU keeps rs2 unsigned, MUL and the U-variants are unsigned.
  always_comb begin
    rs1_neg = 1'b0;
    rs2_neg = 1'b0;
    case (bus.op_i)
      INST_MULH, INST_DIV, INST_REM: begin
        rs1_neg = bus.rs1_i[XLEN-1];
        rs2_neg = bus.rs2_i[XLEN-1];
      end
      INST_MULHSU: rs1_neg = bus.rs1_i[XLEN-1];
      default: ;
    endcase
  end

  assign mag_a = rs1_neg ? (~bus.rs1_i + 1'b1) : bus.rs1_i;
  assign mag_b = rs2_neg ? (~bus.rs2_i + 1'b1) : bus.rs2_i;

  assign div_zero = (bus.rs2_i == ZeroWord);
  assign div_ovf  = ((bus.op_i == INST_DIV) || (bus.op_i == INST_REM)) &&
                    (bus.rs1_i == 32'h8000_0000) && (bus.rs2_i == 32'hFFFF_FFFF);
  assign special  = is_div(bus.op_i) & (div_zero | div_ovf);

  always_comb begin
    special_res = ZeroWord;
    case (bus.op_i)
      INST_DIV, INST_DIVU: special_res = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
      INST_REM, INST_REMU: special_res = div_zero ? bus.rs1_i : ZeroWord;
      default: ;
    endcase
  end

  // Remainder follows the dividend; quotient and product follow the sign xor.
  assign neg_acc = (bus.op_i == INST_REM) ? rs1_neg : (rs1_neg ^ rs2_neg);

  // One restoring-division step on {remainder, dividend msb}.
  assign div_tmp  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff = div_tmp - {1'b0, b_q};
  assign div_ge   = ~div_diff[XLEN];

  always_comb begin
    if (is_div(op_q)) begin
      acc_step = {(div_ge ? div_diff[XLEN-1:0] : div_tmp[XLEN-1:0]),
                  acc_q[XLEN-2:0], div_ge};
    end else begin
      acc_step = acc_q + (b_q[0] ? a_q : '0);
    end
  end

  assign prod_fix = neg_q ? (~acc_step + 1'b1) : acc_step;
  assign div_sel  = ((op_q == INST_DIV) || (op_q == INST_DIVU)) ?
                    acc_step[XLEN-1:0] : acc_step[2*XLEN-1:XLEN];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_we_d = rd_we_q;
    waddr_d = waddr_q;
    neg_d   = neg_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d    = bus.op_i;
          rd_we_d = bus.rd_we_i;
          waddr_d = bus.rd_waddr_i;
          neg_d   = neg_acc;
          cnt_d   = '0;
          a_d     = {{XLEN{1'b0}}, mag_a};
          b_d     = mag_b;
          acc_d   = is_div(bus.op_i) ? {{XLEN{1'b0}}, mag_a} : '0;
          res_d   = special_res;
          state_d = special ? StDone : StCalc;
        end
      end
      StCalc: begin
        acc_d = acc_step;
        a_d   = a_q << 1;
        b_d   = is_div(op_q) ? b_q : (b_q >> 1);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = StDone;
          if (is_div(op_q)) begin
            res_d = neg_q ? (~div_sel + 1'b1) : div_sel;
          end else begin
            res_d = (op_q == INST_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
          end
        end
        if (bus.kill_i) begin
          state_d = StIdle;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= 3'd0;
      rd_we_q <= 1'b0;
      waddr_q <= ZeroReg;
      neg_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= ZeroWord;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_we_q <= rd_we_d;
      waddr_q <= waddr_d;
      neg_q   <= neg_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  // Write data comes only from registers; kill can still veto the DONE-cycle write.
  always_comb begin
    bus.muldiv_reg_we_o    = (state_q == StDone) & rd_we_q & ~bus.kill_i;
    bus.muldiv_reg_waddr_o = bus.muldiv_reg_we_o ? waddr_q : ZeroReg;
    bus.muldiv_reg_wdata_o = bus.muldiv_reg_we_o ? res_q : ZeroWord;
    bus.busy_o             = ((state_q == StCalc) & ~bus.kill_i) | accept;
    bus.req_muldiv_o       = ((state_q != StIdle) & ~bus.kill_i) | accept;
  end

endmodule
